// File: rtl/timer0_unit.sv
// 8051 Timer 0: modes 0/1/2 counting, gate and external-count control, SFR byte writes.
// Optional macro TIMER0_MODE3_EN enables mode 3 (split TL0/TH0 with TH0 run by TR1).
`ifndef SFR_OP_LEN
`define SFR_OP_LEN 4
`endif
`ifndef OP_TL0_WR_BYTE
`define OP_TL0_WR_BYTE 0
`endif
`ifndef OP_TH0_WR_BYTE
`define OP_TH0_WR_BYTE 1
`endif

module timer0_unit (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_tick,
    input  logic [3:0]             i_tmod,
    input  logic                   i_tr0,
    input  logic                   i_tr1,
    input  logic                   i_int0,
    input  logic                   i_t0,
    input  logic [7:0]             i_byte,
    input  logic [`SFR_OP_LEN-1:0] i_op,
    output logic [7:0]             o_tl0,
    output logic [7:0]             o_th0,
    output logic                   o_tf0_ovf,
    output logic                   o_tf1_ovf
);

    localparam logic [1:0] MODE_13BIT  = 2'd0;
    localparam logic [1:0] MODE_16BIT  = 2'd1;
    localparam logic [1:0] MODE_RELOAD = 2'd2;

    logic [7:0] tl0_q, tl0_d;
    logic [7:0] th0_q, th0_d;
    logic       t0_prev_q, t0_prev_d;
    logic       tf0_q, tf0_d;
    logic       tf1_q, tf1_d;

    logic       run0_c;
    logic       inc0_c;
    logic       tl0_wr_c;
    logic       th0_wr_c;
    logic [1:0] mode_c;
    logic       unused_ok_c;

    // Count enable: gated run control, optional T0 falling-edge detect across ticks.
    always_comb begin
        mode_c   = i_tmod[1:0];
        tl0_wr_c = i_op[`OP_TL0_WR_BYTE];
        th0_wr_c = i_op[`OP_TH0_WR_BYTE];
        run0_c   = i_tr0 & (~i_tmod[3] | i_int0);
        inc0_c   = i_tick & run0_c & (~i_tmod[2] | (t0_prev_q & ~i_t0));
    end

    // Next-state: counting first, then SFR writes override the counted value.
    always_comb begin
        tl0_d     = tl0_q;
        th0_d     = th0_q;
        tf0_d     = 1'b0;
        tf1_d     = 1'b0;
        t0_prev_d = i_tick ? i_t0 : t0_prev_q;

        if (inc0_c && !tl0_wr_c) begin
            case (mode_c)
                MODE_13BIT: begin
                    tl0_d = {tl0_q[7:5], tl0_q[4:0] + 5'd1};
                    if (tl0_q[4:0] == 5'h1F) begin
                        th0_d = th0_q + 8'd1;
                        tf0_d = (th0_q == 8'hFF) & ~th0_wr_c;
                    end
                end
                MODE_16BIT: begin
                    tl0_d = tl0_q + 8'd1;
                    if (tl0_q == 8'hFF) begin
                        th0_d = th0_q + 8'd1;
                        tf0_d = (th0_q == 8'hFF) & ~th0_wr_c;
                    end
                end
                MODE_RELOAD: begin
                    // A TH0 write on the reload cycle supplies the reload value directly.
                    if (tl0_q == 8'hFF) begin
                        tl0_d = th0_wr_c ? i_byte : th0_q;
                        tf0_d = 1'b1;
                    end else begin
                        tl0_d = tl0_q + 8'd1;
                    end
                end
                default: begin
`ifdef TIMER0_MODE3_EN
                    tl0_d = tl0_q + 8'd1;
                    tf0_d = (tl0_q == 8'hFF);
`endif
                end
            endcase
        end

`ifdef TIMER0_MODE3_EN
        // Mode 3: TH0 runs as an independent 8-bit timer under TR1.
        if (mode_c == 2'd3 && i_tick && i_tr1 && !th0_wr_c) begin
            th0_d = th0_q + 8'd1;
            tf1_d = (th0_q == 8'hFF);
        end
`endif

        if (tl0_wr_c) tl0_d = i_byte;
        if (th0_wr_c) th0_d = i_byte;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tl0_q     <= 8'h00;
            th0_q     <= 8'h00;
            t0_prev_q <= 1'b1;
            tf0_q     <= 1'b0;
            tf1_q     <= 1'b0;
        end else begin
            tl0_q     <= tl0_d;
            th0_q     <= th0_d;
            t0_prev_q <= t0_prev_d;
            tf0_q     <= tf0_d;
            tf1_q     <= tf1_d;
        end
    end

    // TR1 and the remaining SFR op bits are not used in every configuration.
    assign unused_ok_c = ^{i_tr1, i_op};

    assign o_tl0     = tl0_q;
    assign o_th0     = th0_q;
    assign o_tf0_ovf = tf0_q;
    assign o_tf1_ovf = tf1_q;

endmodule
